// File: rtl/acc_cpu_pkg.sv
// Shared types and constants for the 8-bit accumulator CPU control path.
package acc_cpu_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    S_IF1 = 3'd0,
    S_IF2 = 3'd1,
    S_DEC = 3'd2,
    S_MEM = 3'd3,
    S_EX  = 3'd4,
    S_ST  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_NOT = 3'b011,
    OP_LDA = 3'b100,
    OP_STA = 3'b101,
    OP_JMP = 3'b110,
    OP_JZ  = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_t;

  localparam logic [1:0] ACC_SEL_MEM = 2'b00;
  localparam logic [1:0] ACC_SEL_ALU = 2'b01;

endpackage

// File: rtl/acc_cpu_ctrl_decode.sv
// Combinational control decoder: maps FSM state, opcode, acc_zero and
// mem_ready onto every datapath select, load enable and memory strobe.
module acc_cpu_ctrl_decode
  import acc_cpu_pkg::*;
(
  input  logic [2:0] state_i,
  input  logic [2:0] opcode_i,
  input  logic       acc_zero_i,
  input  logic       mem_ready_i,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic       addr_sel_o,
  output logic       pc_sel_o,
  output logic       pc_ld_o,
  output logic       ir_hi_ld_o,
  output logic       ir_lo_ld_o,
  output logic       acc_ld_o,
  output logic [1:0] acc_sel_o,
  output logic [1:0] alu_op_o,
  output logic       instr_done_o
);

  always_comb begin
    mem_rd_o     = 1'b0;
    mem_wr_o     = 1'b0;
    addr_sel_o   = 1'b0;
    pc_sel_o     = 1'b0;
    pc_ld_o      = 1'b0;
    ir_hi_ld_o   = 1'b0;
    ir_lo_ld_o   = 1'b0;
    acc_ld_o     = 1'b0;
    acc_sel_o    = ACC_SEL_MEM;
    alu_op_o     = ALU_ADD;
    instr_done_o = 1'b0;
    case (state_t'(state_i))
      S_IF1: begin
        mem_rd_o   = 1'b1;
        ir_hi_ld_o = mem_ready_i;
        pc_ld_o    = mem_ready_i;
      end
      S_IF2: begin
        mem_rd_o   = 1'b1;
        ir_lo_ld_o = mem_ready_i;
        pc_ld_o    = mem_ready_i;
      end
      S_DEC: begin
        case (opcode_t'(opcode_i))
          OP_NOT: begin
            acc_sel_o    = ACC_SEL_ALU;
            alu_op_o     = ALU_NOT;
            acc_ld_o     = 1'b1;
            instr_done_o = 1'b1;
          end
          OP_JMP: begin
            pc_sel_o     = 1'b1;
            pc_ld_o      = 1'b1;
            instr_done_o = 1'b1;
          end
          OP_JZ: begin
            pc_sel_o     = acc_zero_i;
            pc_ld_o      = acc_zero_i;
            instr_done_o = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        // Non-LDA reads only latch the MDR here; the ALU result lands in S_EX.
        addr_sel_o = 1'b1;
        mem_rd_o   = 1'b1;
        if (mem_ready_i && opcode_t'(opcode_i) == OP_LDA) begin
          acc_sel_o    = ACC_SEL_MEM;
          acc_ld_o     = 1'b1;
          instr_done_o = 1'b1;
        end
      end
      S_EX: begin
        acc_sel_o    = ACC_SEL_ALU;
        alu_op_o     = opcode_i[1:0];
        acc_ld_o     = 1'b1;
        instr_done_o = 1'b1;
      end
      S_ST: begin
        addr_sel_o   = 1'b1;
        mem_wr_o     = 1'b1;
        instr_done_o = mem_ready_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_cpu_controller.sv
// Multicycle fetch/decode/execute sequencer: state register and next-state
// logic; outputs come from the decoder and are forced low during reset.
module acc_cpu_controller
  import acc_cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       acc_zero,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       addr_sel,
  output logic       pc_sel,
  output logic       pc_ld,
  output logic       ir_hi_ld,
  output logic       ir_lo_ld,
  output logic       acc_ld,
  output logic [1:0] acc_sel,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic [2:0] dbg_state_o
);

  // Memory handshake: a strobe is held with its address select until the
  // edge on which mem_ready is sampled high; that edge completes the access.
  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IF1;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF1: if (mem_ready) state_d = S_IF2;
      S_IF2: if (mem_ready) state_d = S_DEC;
      S_DEC: begin
        case (opcode_t'(opcode))
          OP_ADD, OP_SUB, OP_AND, OP_LDA: state_d = S_MEM;
          OP_STA:                         state_d = S_ST;
          default:                        state_d = S_IF1;
        endcase
      end
      S_MEM: if (mem_ready) state_d = (opcode_t'(opcode) == OP_LDA) ? S_IF1 : S_EX;
      S_EX:  state_d = S_IF1;
      S_ST:  if (mem_ready) state_d = S_IF1;
      default: state_d = S_IF1;
    endcase
  end

  logic       d_mem_rd, d_mem_wr, d_addr_sel, d_pc_sel, d_pc_ld;
  logic       d_ir_hi_ld, d_ir_lo_ld, d_acc_ld, d_instr_done;
  logic [1:0] d_acc_sel, d_alu_op;

  acc_cpu_ctrl_decode u_decode (
    .state_i      (state_q),
    .opcode_i     (opcode),
    .acc_zero_i   (acc_zero),
    .mem_ready_i  (mem_ready),
    .mem_rd_o     (d_mem_rd),
    .mem_wr_o     (d_mem_wr),
    .addr_sel_o   (d_addr_sel),
    .pc_sel_o     (d_pc_sel),
    .pc_ld_o      (d_pc_ld),
    .ir_hi_ld_o   (d_ir_hi_ld),
    .ir_lo_ld_o   (d_ir_lo_ld),
    .acc_ld_o     (d_acc_ld),
    .acc_sel_o    (d_acc_sel),
    .alu_op_o     (d_alu_op),
    .instr_done_o (d_instr_done)
  );

  // Reset gating is combinational so a mid-wait reset drops strobes at once.
  assign mem_rd      = d_mem_rd     & rst_n;
  assign mem_wr      = d_mem_wr     & rst_n;
  assign addr_sel    = d_addr_sel   & rst_n;
  assign pc_sel      = d_pc_sel     & rst_n;
  assign pc_ld       = d_pc_ld      & rst_n;
  assign ir_hi_ld    = d_ir_hi_ld   & rst_n;
  assign ir_lo_ld    = d_ir_lo_ld   & rst_n;
  assign acc_ld      = d_acc_ld     & rst_n;
  assign acc_sel     = d_acc_sel    & {2{rst_n}};
  assign alu_op      = d_alu_op     & {2{rst_n}};
  assign instr_done  = d_instr_done & rst_n;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_acc_cpu_controller.sv
// Directed bench for acc_cpu_controller: per-cycle expected control words
// built from the instruction sequencing rules, plus an instr_done count.
module tb_acc_cpu_controller;
  import acc_cpu_pkg::*;

  logic       clk, rst_n;
  logic [2:0] opcode;
  logic       acc_zero, mem_ready;
  logic       mem_rd, mem_wr, addr_sel, pc_sel, pc_ld;
  logic       ir_hi_ld, ir_lo_ld, acc_ld, instr_done;
  logic [1:0] acc_sel, alu_op;
  logic [2:0] dbg_state;

  acc_cpu_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .acc_zero    (acc_zero),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .addr_sel    (addr_sel),
    .pc_sel      (pc_sel),
    .pc_ld       (pc_ld),
    .ir_hi_ld    (ir_hi_ld),
    .ir_lo_ld    (ir_lo_ld),
    .acc_ld      (acc_ld),
    .acc_sel     (acc_sel),
    .alu_op      (alu_op),
    .instr_done  (instr_done),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_instr  = 0;
  int n_done   = 0;
  logic [15:0] exp_q[$];

  always @(posedge clk) if (rst_n && instr_done) n_done++;

  wire [15:0] obs = {dbg_state, mem_rd, mem_wr, addr_sel, pc_sel, pc_ld,
                     ir_hi_ld, ir_lo_ld, acc_ld, acc_sel, alu_op, instr_done};

  function automatic logic [15:0] ev(logic [2:0] s, logic rd, logic wr,
      logic as, logic ps, logic pl, logic ih, logic il, logic al,
      logic [1:0] asel, logic [1:0] op, logic dn);
    return {s, rd, wr, as, ps, pl, ih, il, al, asel, op, dn};
  endfunction

  task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one cycle: drive mem_ready, compare against the queued expectation
  task automatic cyc(string tag, logic rdy, logic [15:0] e);
    mem_ready = rdy;
    exp_q.push_back(e);
    #1;
    check(tag, obs, exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic do_instr(string tag, logic [2:0] op, logic z, int if_wait, int mem_wait);
    opcode   = op;
    acc_zero = z;
    for (int i = 0; i < if_wait; i++)
      cyc({tag, ".if1w"}, 1'b0, ev(S_IF1, 1,0,0,0,0,0,0,0, 2'b00, 2'b00, 0));
    cyc({tag, ".if1"}, 1'b1, ev(S_IF1, 1,0,0,0,1,1,0,0, 2'b00, 2'b00, 0));
    cyc({tag, ".if2"}, 1'b1, ev(S_IF2, 1,0,0,0,1,0,1,0, 2'b00, 2'b00, 0));
    case (op)
      OP_NOT: cyc({tag, ".dec"}, 1'($urandom_range(0, 1)),
                  ev(S_DEC, 0,0,0,0,0,0,0,1, 2'b01, 2'b11, 1));
      OP_JMP: cyc({tag, ".dec"}, 1'($urandom_range(0, 1)),
                  ev(S_DEC, 0,0,0,1,1,0,0,0, 2'b00, 2'b00, 1));
      OP_JZ:  cyc({tag, ".dec"}, 1'($urandom_range(0, 1)),
                  ev(S_DEC, 0,0,0,z,z,0,0,0, 2'b00, 2'b00, 1));
      OP_STA: begin
        cyc({tag, ".dec"}, 1'($urandom_range(0, 1)), ev(S_DEC, 0,0,0,0,0,0,0,0, 2'b00, 2'b00, 0));
        for (int i = 0; i < mem_wait; i++)
          cyc({tag, ".stw"}, 1'b0, ev(S_ST, 0,1,1,0,0,0,0,0, 2'b00, 2'b00, 0));
        cyc({tag, ".st"}, 1'b1, ev(S_ST, 0,1,1,0,0,0,0,0, 2'b00, 2'b00, 1));
      end
      OP_LDA: begin
        cyc({tag, ".dec"}, 1'($urandom_range(0, 1)), ev(S_DEC, 0,0,0,0,0,0,0,0, 2'b00, 2'b00, 0));
        for (int i = 0; i < mem_wait; i++)
          cyc({tag, ".memw"}, 1'b0, ev(S_MEM, 1,0,1,0,0,0,0,0, 2'b00, 2'b00, 0));
        cyc({tag, ".mem"}, 1'b1, ev(S_MEM, 1,0,1,0,0,0,0,1, 2'b00, 2'b00, 1));
      end
      default: begin
        cyc({tag, ".dec"}, 1'($urandom_range(0, 1)), ev(S_DEC, 0,0,0,0,0,0,0,0, 2'b00, 2'b00, 0));
        for (int i = 0; i < mem_wait; i++)
          cyc({tag, ".memw"}, 1'b0, ev(S_MEM, 1,0,1,0,0,0,0,0, 2'b00, 2'b00, 0));
        cyc({tag, ".mem"}, 1'b1, ev(S_MEM, 1,0,1,0,0,0,0,0, 2'b00, 2'b00, 0));
        cyc({tag, ".ex"}, 1'($urandom_range(0, 1)),
            ev(S_EX, 0,0,0,0,0,0,0,1, 2'b01, op[1:0], 1));
      end
    endcase
    n_instr++;
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 3'b000;
    acc_zero  = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset", obs, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    do_instr("lda",   OP_LDA, 1'b0, 0, 0);
    do_instr("add",   OP_ADD, 1'b0, 0, 0);
    do_instr("sta",   OP_STA, 1'b0, 0, 2);
    do_instr("jz1",   OP_JZ,  1'b1, 0, 0);
    do_instr("jz0",   OP_JZ,  1'b0, 0, 0);
    do_instr("subw",  OP_SUB, 1'b0, 1, 1);
    do_instr("ldaw",  OP_LDA, 1'b1, 2, 2);

    for (int i = 0; i < 8; i++)
      do_instr($sformatf("b2b%0d", i), 3'(i), 1'($urandom_range(0, 1)), 0, 0);

    // abandon an ADD while its operand read is stalled
    opcode   = OP_ADD;
    acc_zero = 1'b0;
    cyc("abort.if1", 1'b1, ev(S_IF1, 1,0,0,0,1,1,0,0, 2'b00, 2'b00, 0));
    cyc("abort.if2", 1'b1, ev(S_IF2, 1,0,0,0,1,0,1,0, 2'b00, 2'b00, 0));
    cyc("abort.dec", 1'b0, ev(S_DEC, 0,0,0,0,0,0,0,0, 2'b00, 2'b00, 0));
    mem_ready = 1'b0;
    #1;
    check("abort.memw", obs, ev(S_MEM, 1,0,1,0,0,0,0,0, 2'b00, 2'b00, 0));
    #1;
    rst_n = 1'b0;
    #1;
    check("abort.rst", obs, 16'h0000);
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    check("abort.hold", obs, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    do_instr("restart", OP_LDA, 1'b0, 0, 0);

    check("done_count", 16'(n_done), 16'(n_instr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
